// File: rtl/alu32_issue_ctrl.sv
// Purpose: issue sequencer in front of ALU32; launches one op, waits SETTLE_CYCLES, returns the captured status.
// Latency: the response is valid SETTLE_CYCLES edges after acceptance (0 edges for an illegal opcode); throughput is 1 op per SETTLE_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE; the response is held indefinitely while rsp_ready=0. ALU32_ISSUE_STATS_EN adds op_count/ovf_count.
module alu32_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_illegal
`ifdef ALU32_ISSUE_STATS_EN
  ,
  output logic [31:0]      op_count,
  output logic [31:0]      ovf_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ill_q, rsp_ill_d;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b0110, 4'b1100: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  // Next-state logic: accept in IDLE, count down the settle window, hold the response until taken.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ill_d    = rsp_ill_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          alu_op_d = req_opcode;
          if (is_legal(req_opcode)) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_INIT;
          end else begin
            // Illegal ops never touch the ALU output; answer straight away.
            state_d      = RESP;
            rsp_result_d = '0;
            rsp_cout_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_zero_d   = 1'b1;
            rsp_ill_d    = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          rsp_result_d = alu_result;
          rsp_cout_d   = alu_cout;
          rsp_ovf_d    = alu_overflow;
          rsp_zero_d   = (alu_result == '0);
          rsp_ill_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_illegal  = rsp_ill_q;

`ifdef ALU32_ISSUE_STATS_EN
  logic [31:0] op_count_q, op_count_d;
  logic [31:0] ovf_count_q, ovf_count_d;

  // Counters advance on each response handshake and wrap naturally.
  always_comb begin
    op_count_d  = op_count_q;
    ovf_count_d = ovf_count_q;
    if (rsp_valid && rsp_ready) begin
      op_count_d = op_count_q + 32'd1;
      if (rsp_ovf_q) begin
        ovf_count_d = ovf_count_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q  <= '0;
      ovf_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign op_count  = op_count_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule
